timer_arbiter: RTL and testbench

//  Shares one TriggeredTimer between NUM_REQ requesters, e.g. the X/Y/Z step-pulse and servo-dwell sequencers.

---
 rtl/timer_arbiter_pkg.sv | 15 +
 rtl/timer_arbiter_if.sv | 30 +++
 rtl/timer_arbiter_rr_picker.sv | 38 +++
 rtl/timer_arbiter.sv | 119 +++++++++++
 tb/tb_timer_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_arbiter_pkg.sv
// Shared types and limits for the timer arbiter and its round-robin picker.
package timer_arbiter_pkg;

  localparam int unsigned TIMER_ARB_MAX_REQ = 8;
  localparam int unsigned BYTE_BITS         = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    RELEASE
  } timer_arb_state_t;

endpackage

// File: rtl/timer_arbiter_if.sv
// Requester and timer handshake bundle between the motion sequencers, the arbiter and the timer.
interface timer_arbiter_if
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned COUNTER_BITS = BYTE_BITS
);

  logic                              en;
  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ*COUNTER_BITS-1:0]   req_count;
  logic [NUM_REQ-1:0]                grant;
  logic [NUM_REQ-1:0]                done;
  logic                              busy;
  logic [COUNTER_BITS-1:0]           timer_count;
  logic                              timer_trigger;
  logic                              timer_done;
  logic                              timer_rdy;

  modport master (
    output en, req, req_count, timer_done, timer_rdy,
    input  grant, done, busy, timer_count, timer_trigger
  );

  modport slave (
    input  en, req, req_count, timer_done, timer_rdy,
    output grant, done, busy, timer_count, timer_trigger
  );

endinterface

// File: rtl/timer_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping at NUM_REQ.
module rr_picker
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  input  logic               en_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  if (NUM_REQ < 2 || NUM_REQ > TIMER_ARB_MAX_REQ) begin : g_bad_num_req
    $error("rr_picker: NUM_REQ out of range");
  end

  always_comb begin
    int unsigned      pos;
    logic [IDX_W-1:0] cand;
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // rr_ptr is always < NUM_REQ, so one subtraction is enough to wrap
      pos = 32'(rr_ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IDX_W'(pos);
      if (en_i && !valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one TriggeredTimer between NUM_REQ motion sequencers.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned COUNTER_BITS = BYTE_BITS
) (
  input  logic           clk,
  input  logic           reset,
  timer_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  timer_arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    trig_q, trig_d;
  logic [COUNTER_BITS-1:0] count_q, count_d;

  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;
  logic [COUNTER_BITS-1:0] pick_count;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (bus.req),
    .rr_ptr_i (rr_q),
    .en_i     (bus.en),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  assign pick_count = bus.req_count[pick_idx*COUNTER_BITS +: COUNTER_BITS];

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    trig_d  = trig_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          count_d = pick_count;
          busy_d  = 1'b1;
          // a zero-length job never reaches the timer
          state_d = (pick_count == '0) ? RELEASE : ISSUE;
        end
      end
      ISSUE: begin
        if (bus.timer_rdy) begin
          trig_d  = 1'b1;
          state_d = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        if (bus.timer_done) begin
          trig_d  = 1'b0;
          state_d = RELEASE;
        end else if (!bus.timer_rdy) begin
          trig_d  = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.timer_done && bus.timer_rdy) state_d = RELEASE;
      end
      RELEASE: begin
        // grant_q is one-hot on the owner, so masking with req suppresses an abandoned job
        done_d  = grant_q & bus.req;
        grant_d = '0;
        busy_d  = 1'b0;
        rr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      trig_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      trig_q  <= trig_d;
      count_q <= count_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.timer_trigger = trig_q;
  assign bus.timer_count   = count_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with a behavioural TriggeredTimer clocked by a div-2 enable.
module tb_timer_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic tmr_rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  timer_arbiter_if #(.NUM_REQ(3), .COUNTER_BITS(8)) bus ();

  timer_arbiter #(.NUM_REQ(3), .COUNTER_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Timer model: accepts a trigger on a clk_en cycle, counts down on clk_en, holds done until retriggered.
  logic       clk_en_q, t_busy_q, t_done_q;
  logic [7:0] t_cnt_q;

  always_ff @(posedge clk or negedge tmr_rst_n) begin
    if (!tmr_rst_n) begin
      clk_en_q <= 1'b0;
      t_busy_q <= 1'b0;
      t_done_q <= 1'b0;
      t_cnt_q  <= '0;
    end else begin
      clk_en_q <= ~clk_en_q;
      if (clk_en_q) begin
        if (t_busy_q) begin
          if (t_cnt_q <= 8'd1) begin
            t_busy_q <= 1'b0;
            t_done_q <= 1'b1;
          end else begin
            t_cnt_q <= t_cnt_q - 8'd1;
          end
        end else if (bus.timer_trigger) begin
          t_busy_q <= 1'b1;
          t_cnt_q  <= bus.timer_count;
          t_done_q <= 1'b0;
        end
      end
    end
  end

  assign bus.timer_rdy  = !t_busy_q;
  assign bus.timer_done = t_done_q && !bus.timer_trigger;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.done != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Returns on the first sample where the trigger has been seen high and is low again (WAIT_DONE).
  task automatic wait_trig_cycle(input int max, output bit ok);
    bit seen;
    seen = 1'b0;
    ok   = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (bus.timer_trigger) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    bit         ok;
    int         dn;
    logic [2:0] exp_g [4];
    logic [7:0] exp_c [4];

    // 1: reset held with all requests pending
    reset         = 1'b0;
    tmr_rst_n     = 1'b0;
    bus.en        = 1'b1;
    bus.req       = 3'b111;
    bus.req_count = {8'd2, 8'd4, 8'd3};
    tick(); tick(); tick();
    chk("t1_rst_grant", bus.grant, 3'b000);
    chk("t1_rst_done", bus.done, 3'b000);
    chk("t1_rst_busy", bus.busy, 1'b0);
    chk("t1_rst_trig", bus.timer_trigger, 1'b0);
    chk("t1_rst_count", bus.timer_count, 8'd0);
    bus.en    = 1'b0;
    reset     = 1'b1;
    tmr_rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t1_en0_grant", bus.grant, 3'b000);
    chk("t1_en0_busy", bus.busy, 1'b0);

    // 2: single request, count 5
    bus.en        = 1'b1;
    bus.req       = 3'b010;
    bus.req_count = {8'd0, 8'd5, 8'd0};
    tick();
    chk("t2_grant", bus.grant, 3'b010);
    chk("t2_count", bus.timer_count, 8'd5);
    chk("t2_busy", bus.busy, 1'b1);
    chk("t2_trig_pre", bus.timer_trigger, 1'b0);
    tick();
    chk("t2_trig_on", bus.timer_trigger, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!bus.timer_rdy) begin
        ok = 1'b1;
        break;
      end
      chk("t2_trig_held", bus.timer_trigger, 1'b1);
      tick();
    end
    chk("t2_accepted", ok, 1'b1);
    chk("t2_trig_at_accept", bus.timer_trigger, 1'b1);
    tick();
    chk("t2_trig_dropped", bus.timer_trigger, 1'b0);
    chk("t2_busy_mid", bus.busy, 1'b1);
    wait_done(40, ok);
    chk("t2_done_seen", ok, 1'b1);
    chk("t2_done", bus.done, 3'b010);
    chk("t2_busy_off", bus.busy, 1'b0);
    chk("t2_grant_off", bus.grant, 3'b000);
    bus.req = 3'b000;
    tick();
    chk("t2_done_1clk", bus.done, 3'b000);

    // 4: zero count skips the timer; done two clocks after req
    bus.req       = 3'b001;
    bus.req_count = {8'd0, 8'd0, 8'd0};
    tick();
    chk("t4_grant", bus.grant, 3'b001);
    chk("t4_trig_a", bus.timer_trigger, 1'b0);
    tick();
    chk("t4_done", bus.done, 3'b001);
    chk("t4_busy_off", bus.busy, 1'b0);
    chk("t4_trig_b", bus.timer_trigger, 1'b0);
    bus.req = 3'b000;
    tick();
    chk("t4_done_clr", bus.done, 3'b000);
    // rr_ptr=1 must now favour req1 over req0
    bus.req = 3'b011;
    tick();
    chk("t4_rr_ptr_one", bus.grant, 3'b010);
    tick();
    chk("t4b_done", bus.done, 3'b010);
    bus.req = 3'b000;
    tick();
    // rr_ptr=2 favours req2, then wraps to 0
    bus.req = 3'b101;
    tick();
    chk("t4c_rr_ptr_two", bus.grant, 3'b100);
    tick();
    chk("t4c_done", bus.done, 3'b100);
    bus.req = 3'b000;

    // 5: owner abandons its job mid-flight
    bus.req       = 3'b001;
    bus.req_count = {8'd2, 8'd0, 8'd6};
    tick();
    chk("t5_grant", bus.grant, 3'b001);
    chk("t5_count", bus.timer_count, 8'd6);
    bus.req = 3'b101;
    wait_trig_cycle(30, ok);
    chk("t5_wait_done_reached", ok, 1'b1);
    chk("t5_busy_mid", bus.busy, 1'b1);
    bus.req_count = {8'd2, 8'd0, 8'd9};
    tick();
    chk("t5_count_held", bus.timer_count, 8'd6);
    bus.req = 3'b100;
    dn = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done != '0) dn++;
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_busy_fell", ok, 1'b1);
    chk("t5_done_suppressed", dn, 0);
    chk("t5_grant_off", bus.grant, 3'b000);
    tick();
    chk("t5_next_grant", bus.grant, 3'b100);
    chk("t5_next_count", bus.timer_count, 8'd2);
    wait_done(40, ok);
    chk("t5_next_done_seen", ok, 1'b1);
    chk("t5_next_done", bus.done, 3'b100);
    bus.req = 3'b000;

    // 3: all three held, round-robin order
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_c[0] = 8'd3;   exp_c[1] = 8'd4;   exp_c[2] = 8'd2;   exp_c[3] = 8'd3;
    bus.req       = 3'b111;
    bus.req_count = {8'd2, 8'd4, 8'd3};
    for (int j = 0; j < 4; j++) begin
      wait_grant(4, ok);
      chk("t3_grant_seen", ok, 1'b1);
      chk("t3_grant", bus.grant, exp_g[j]);
      chk("t3_count", bus.timer_count, exp_c[j]);
      chk("t3_no_extra_done", bus.done, 3'b000);
      wait_done(60, ok);
      chk("t3_done_seen", ok, 1'b1);
      chk("t3_done", bus.done, exp_g[j]);
      chk("t3_done_before_grant", bus.grant, 3'b000);
      if (j == 3) bus.req = 3'b000;
    end
    tick();
    chk("t3_idle_after", bus.grant, 3'b000);

    // 6: asynchronous reset while waiting on the timer
    bus.req       = 3'b010;
    bus.req_count = {8'd0, 8'd5, 8'd0};
    tick();
    chk("t6_grant", bus.grant, 3'b010);
    wait_trig_cycle(30, ok);
    chk("t6_wait_done_reached", ok, 1'b1);
    chk("t6_busy_mid", bus.busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_grant", bus.grant, 3'b000);
    chk("t6_async_busy", bus.busy, 1'b0);
    chk("t6_async_trig", bus.timer_trigger, 1'b0);
    chk("t6_async_count", bus.timer_count, 8'd0);
    chk("t6_async_done", bus.done, 3'b000);
    bus.req       = 3'b011;
    bus.req_count = {8'd0, 8'd0, 8'd0};
    tick();
    reset = 1'b1;
    tick();
    chk("t6_rr_reset", bus.grant, 3'b001);
    tick();
    chk("t6_done", bus.done, 3'b001);
    bus.req = 3'b000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
